// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, round/word counts and GF(2^8) arithmetic.
package aes_pkg;

  localparam logic [1:0] KL_NONE = 2'b00;
  localparam logic [1:0] KL_128  = 2'b11;
  localparam logic [1:0] KL_192  = 2'b10;
  localparam logic [1:0] KL_256  = 2'b01;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  localparam int NUM_WORDS = 60;

  typedef enum logic [1:0] {K_IDLE, K_EXP, K_FIN} key_state_e;
  typedef enum logic [1:0] {E_IDLE, E_ENC, E_DEC} eng_state_e;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return NK_192;
      KL_256:  return NK_256;
      default: return NK_128;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return NR_192;
      KL_256:  return NR_256;
      default: return NR_128;
    endcase
  endfunction

  // Index of the final schedule word, 4*(Nr+1)-1.
  function automatic logic [5:0] last_word_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return 6'd51;
      KL_256:  return 6'd59;
      default: return 6'd43;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Column byte 0 sits in the top bits; row j of the matrix is the coefficient set rotated by j.
  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [7:0]   m [4];
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] r;
    if (inv) begin
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
      for (int j = 0; j < 4; j++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gf_mul(a[k], m[2'(k - j)]);
        r[127-32*c-8*j -: 8] = b;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward/inverse AES S-box built from the GF(2^8) inverse (x^254) and the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  input  logic       inv_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  logic [7:0] x;
  logic [7:0] sq;
  logic [7:0] y;

  always_comb begin
    x  = inv_i ? inv_affine(in_i) : in_i;
    sq = x;
    y  = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq = gf_mul(sq, sq);
      y  = gf_mul(y, sq);
    end
    out_o = inv_i ? y : affine(y);
  end

endmodule

// File: rtl/aes_core.sv
// Iterative AES-128/192/256 encrypt/decrypt core sharing one round engine and a 60-word key store.
//   state   | meaning
//   K_IDLE  | no expansion running
//   K_EXP   | writing one schedule word per cycle
//   K_FIN   | last word written; key_exp_status rises on this edge
//   E_IDLE  | engine free; starts a pending block (encrypt first) once the key is valid
//   E_ENC   | forward rounds
//   E_DEC   | inverse rounds, round keys in reverse order
module aes_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         pt_valid,
  output logic         pt_in_en,
  output logic         ct_rdy,
  input  logic [127:0] pt_encr,
  output logic [127:0] ct_encr,
  input  logic         ct_valid,
  output logic         ct_in_en,
  output logic         pt_rdy,
  input  logic [127:0] ct_decr,
  output logic [127:0] pt_decr,
  input  logic [1:0]   key_len,
  output logic         key_exp_status,
  output logic         key_inp_en,
  input  logic [255:0] short_key,
  output logic         error
);

  key_state_e   kst_q, kst_d;
  eng_state_e   eng_q, eng_d;
  logic [1:0]   klen_q, klen_d;
  logic [5:0]   kidx_q, kidx_d;
  logic [3:0]   kpos_q, kpos_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         kvalid_q, kvalid_d;
  logic [31:0]  w_q [NUM_WORDS];
  logic         pt_pend_q, pt_pend_d, ct_pend_q, ct_pend_d;
  logic [127:0] pt_blk_q, pt_blk_d, ct_blk_q, ct_blk_d;
  logic         pt_in_en_q, pt_in_en_d, ct_in_en_q, ct_in_en_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   kr_q, kr_d, rnd_q, rnd_d;
  logic [127:0] ct_encr_q, ct_encr_d, pt_decr_q, pt_decr_d;
  logic         ct_rdy_q, ct_rdy_d, pt_rdy_q, pt_rdy_d;
  logic         err_q, err_d;

  logic [3:0]   nk_q, nr_q;
  logic         key_load, key_busy, pt_cap, ct_cap, pt_drop, ct_drop;
  logic [31:0]  kw_temp, kw_prev, ks_in, ks_sub, kw_new;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         dec, last_rnd;
  logic [7:0]   st_b [16];
  logic [7:0]   sb_in [16];
  logic [7:0]   sb_out [16];
  logic [1:0]   row, col, scol;
  logic [127:0] sub_st, ark, round_out;

  assign nk_q       = nk_of(klen_q);
  assign nr_q       = nr_of(klen_q);
  assign key_inp_en = (kst_q == K_IDLE) && (eng_q == E_IDLE) && !pt_pend_q && !ct_pend_q;
  assign key_load   = (key_len != KL_NONE) && key_inp_en;
  assign key_busy   = (kst_q != K_IDLE) || key_load;
  assign pt_cap     = pt_valid && pt_in_en_q;
  assign ct_cap     = ct_valid && ct_in_en_q;
  // A block is only worth holding if a key exists or one is on its way.
  assign pt_drop    = pt_cap && !kvalid_q && !key_busy;
  assign ct_drop    = ct_cap && !kvalid_q && !key_busy;

  // Key schedule word generation.
  assign kw_temp = w_q[kidx_q - 6'd1];
  assign kw_prev = w_q[kidx_q - {2'b00, nk_q}];
  assign ks_in   = (kpos_q == 4'd0) ? {kw_temp[23:0], kw_temp[31:24]} : kw_temp;

  for (genvar g = 0; g < 4; g++) begin : g_ks_sbox
    aes_sbox u_sbox (.in_i(ks_in[31-8*g -: 8]), .inv_i(1'b0), .out_o(ks_sub[31-8*g -: 8]));
  end

  always_comb begin
    if (kpos_q == 4'd0)
      kw_new = kw_prev ^ ks_sub ^ {rcon_q, 24'h000000};
    else if (nk_q == NK_256 && kpos_q == 4'd4)
      kw_new = kw_prev ^ ks_sub;
    else
      kw_new = kw_prev ^ kw_temp;
  end

  // Round datapath.
  assign dec      = (eng_q == E_DEC);
  assign last_rnd = (rnd_q == nr_q);
  assign rk_idx   = (eng_q == E_IDLE) ? (pt_pend_q ? 4'd0 : nr_q) : kr_q;
  assign rk       = {w_q[{rk_idx, 2'b00}], w_q[{rk_idx, 2'b01}],
                     w_q[{rk_idx, 2'b10}], w_q[{rk_idx, 2'b11}]};

  // Byte shifts commute with the S-box, so one row shift feeds either direction.
  always_comb begin
    row  = 2'd0;
    col  = 2'd0;
    scol = 2'd0;
    for (int i = 0; i < 16; i++) st_b[i] = st_q[127-8*i -: 8];
    for (int i = 0; i < 16; i++) begin
      row      = 2'(i);
      col      = 2'(i >> 2);
      scol     = dec ? col - row : col + row;
      sb_in[i] = st_b[{scol, row}];
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_dp_sbox
    aes_sbox u_sbox (.in_i(sb_in[g]), .inv_i(dec), .out_o(sb_out[g]));
  end

  always_comb begin
    sub_st = '0;
    for (int i = 0; i < 16; i++) sub_st[127-8*i -: 8] = sb_out[i];
    ark = sub_st ^ rk;
    if (dec)
      round_out = last_rnd ? ark : mix_columns(ark, 1'b1);
    else
      round_out = (last_rnd ? sub_st : mix_columns(sub_st, 1'b0)) ^ rk;
  end

  always_comb begin
    kst_d      = kst_q;
    eng_d      = eng_q;
    klen_d     = klen_q;
    kidx_d     = kidx_q;
    kpos_d     = kpos_q;
    rcon_d     = rcon_q;
    kvalid_d   = kvalid_q;
    pt_pend_d  = pt_pend_q;
    ct_pend_d  = ct_pend_q;
    pt_blk_d   = pt_blk_q;
    ct_blk_d   = ct_blk_q;
    pt_in_en_d = pt_in_en_q;
    ct_in_en_d = ct_in_en_q;
    st_d       = st_q;
    kr_d       = kr_q;
    rnd_d      = rnd_q;
    ct_encr_d  = ct_encr_q;
    pt_decr_d  = pt_decr_q;
    ct_rdy_d   = ct_rdy_q;
    pt_rdy_d   = pt_rdy_q;
    err_d      = ((key_len != KL_NONE) && !key_inp_en) || pt_drop || ct_drop;

    unique case (kst_q)
      K_IDLE: begin
        if (key_load) begin
          kst_d    = K_EXP;
          kvalid_d = 1'b0;
          klen_d   = key_len;
          kidx_d   = {2'b00, nk_of(key_len)};
          kpos_d   = 4'd0;
          rcon_d   = 8'h01;
        end
      end
      K_EXP: begin
        if (kpos_q == 4'd0) rcon_d = xtime(rcon_q);
        kpos_d = (kpos_q == nk_q - 4'd1) ? 4'd0 : kpos_q + 4'd1;
        if (kidx_q == last_word_of(klen_q)) kst_d = K_FIN;
        else                                kidx_d = kidx_q + 6'd1;
      end
      K_FIN: begin
        kvalid_d = 1'b1;
        kst_d    = K_IDLE;
      end
      default: kst_d = K_IDLE;
    endcase

    unique case (eng_q)
      E_IDLE: begin
        if (kvalid_q && pt_pend_q) begin
          eng_d     = E_ENC;
          st_d      = pt_blk_q ^ rk;
          kr_d      = 4'd1;
          rnd_d     = 4'd1;
          pt_pend_d = 1'b0;
        end else if (kvalid_q && ct_pend_q) begin
          eng_d     = E_DEC;
          st_d      = ct_blk_q ^ rk;
          kr_d      = nr_q - 4'd1;
          rnd_d     = 4'd1;
          ct_pend_d = 1'b0;
        end
      end
      E_ENC, E_DEC: begin
        st_d  = round_out;
        rnd_d = rnd_q + 4'd1;
        kr_d  = dec ? kr_q - 4'd1 : kr_q + 4'd1;
        if (last_rnd) begin
          eng_d = E_IDLE;
          if (dec) begin
            pt_decr_d  = round_out;
            pt_rdy_d   = 1'b1;
            ct_in_en_d = 1'b1;
          end else begin
            ct_encr_d  = round_out;
            ct_rdy_d   = 1'b1;
            pt_in_en_d = 1'b1;
          end
        end
      end
      default: eng_d = E_IDLE;
    endcase

    if (pt_cap && !pt_drop) begin
      pt_pend_d  = 1'b1;
      pt_blk_d   = pt_encr;
      pt_in_en_d = 1'b0;
      ct_rdy_d   = 1'b0;
    end
    if (ct_cap && !ct_drop) begin
      ct_pend_d  = 1'b1;
      ct_blk_d   = ct_decr;
      ct_in_en_d = 1'b0;
      pt_rdy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kst_q      <= K_IDLE;
      eng_q      <= E_IDLE;
      klen_q     <= KL_NONE;
      kidx_q     <= 6'd8;
      kpos_q     <= 4'd0;
      rcon_q     <= 8'h01;
      kvalid_q   <= 1'b0;
      pt_pend_q  <= 1'b0;
      ct_pend_q  <= 1'b0;
      pt_blk_q   <= '0;
      ct_blk_q   <= '0;
      pt_in_en_q <= 1'b1;
      ct_in_en_q <= 1'b1;
      st_q       <= '0;
      kr_q       <= 4'd0;
      rnd_q      <= 4'd0;
      ct_encr_q  <= '0;
      pt_decr_q  <= '0;
      ct_rdy_q   <= 1'b0;
      pt_rdy_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      kst_q      <= kst_d;
      eng_q      <= eng_d;
      klen_q     <= klen_d;
      kidx_q     <= kidx_d;
      kpos_q     <= kpos_d;
      rcon_q     <= rcon_d;
      kvalid_q   <= kvalid_d;
      pt_pend_q  <= pt_pend_d;
      ct_pend_q  <= ct_pend_d;
      pt_blk_q   <= pt_blk_d;
      ct_blk_q   <= ct_blk_d;
      pt_in_en_q <= pt_in_en_d;
      ct_in_en_q <= ct_in_en_d;
      st_q       <= st_d;
      kr_q       <= kr_d;
      rnd_q      <= rnd_d;
      ct_encr_q  <= ct_encr_d;
      pt_decr_q  <= pt_decr_d;
      ct_rdy_q   <= ct_rdy_d;
      pt_rdy_q   <= pt_rdy_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) w_q[i] <= '0;
    end else if (kst_q == K_EXP) begin
      w_q[kidx_q] <= kw_new;
    end else if (key_load) begin
      for (int i = 0; i < 8; i++)
        if (4'(i) < nk_of(key_len)) w_q[i] <= short_key[255-32*i -: 32];
    end
  end

  assign pt_in_en       = pt_in_en_q;
  assign ct_in_en       = ct_in_en_q;
  assign ct_rdy         = ct_rdy_q;
  assign pt_rdy         = pt_rdy_q;
  assign ct_encr        = ct_encr_q;
  assign pt_decr        = pt_decr_q;
  assign key_exp_status = kvalid_q;
  assign error          = err_q;

endmodule

// File: tb/tb_aes_core.sv
// Scoreboard bench for aes_core using FIPS-197 vectors, latency and protocol-error cases.
module tb_aes_core;

  logic         clk = 1'b0;
  logic         reset;
  logic         pt_valid, pt_in_en, ct_rdy;
  logic [127:0] pt_encr, ct_encr;
  logic         ct_valid, ct_in_en, pt_rdy;
  logic [127:0] ct_decr, pt_decr;
  logic [1:0]   key_len;
  logic         key_exp_status, key_inp_en;
  logic [255:0] short_key;
  logic         error;

  aes_core dut (
    .clk(clk), .reset(reset),
    .pt_valid(pt_valid), .pt_in_en(pt_in_en), .ct_rdy(ct_rdy),
    .pt_encr(pt_encr), .ct_encr(ct_encr),
    .ct_valid(ct_valid), .ct_in_en(ct_in_en), .pt_rdy(pt_rdy),
    .ct_decr(ct_decr), .pt_decr(pt_decr),
    .key_len(key_len), .key_exp_status(key_exp_status), .key_inp_en(key_inp_en),
    .short_key(short_key), .error(error)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [191:0] K3  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] C3  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K4  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C4  = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    logic         dec;
    logic [127:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_ct = 0, t_pt = 0, c0 = 0, c1 = 0;
  logic ct_rdy_p = 1'b0, pt_rdy_p = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Result monitor: each rising ready pops the oldest expectation.
  always @(negedge clk) begin
    if (ct_rdy && !ct_rdy_p) begin
      t_ct = cyc;
      chk("ct_expected", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ct_order", 128'(e.dec), 128'(0));
        chk("ct_data", ct_encr, e.data);
        chk("pt_in_en_back", 128'(pt_in_en), 128'(1));
      end
    end
    if (pt_rdy && !pt_rdy_p) begin
      t_pt = cyc;
      chk("pt_expected", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pt_order", 128'(e.dec), 128'(1));
        chk("pt_data", pt_decr, e.data);
        chk("ct_in_en_back", 128'(ct_in_en), 128'(1));
      end
    end
    ct_rdy_p = ct_rdy;
    pt_rdy_p = pt_rdy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [1:0] kl, input logic [255:0] k);
    key_len   = kl;
    short_key = k;
    step();
    key_len = 2'b00;
  endtask

  task automatic wait_key();
    for (int i = 0; i < 100 && !key_exp_status; i++) step();
    chk("key_ready", 128'(key_exp_status), 128'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) step();
    step();
    chk("drain", 128'(sb.size()), 128'(0));
  endtask

  task automatic send_pt(input logic [127:0] d, input logic [127:0] exp);
    chk("pt_in_en_rdy", 128'(pt_in_en), 128'(1));
    pt_valid = 1'b1;
    pt_encr  = d;
    sb.push_back('{dec: 1'b0, data: exp});
    step();
    pt_valid = 1'b0;
    c0 = cyc;
  endtask

  task automatic send_ct(input logic [127:0] d, input logic [127:0] exp);
    chk("ct_in_en_rdy", 128'(ct_in_en), 128'(1));
    ct_valid = 1'b1;
    ct_decr  = d;
    sb.push_back('{dec: 1'b1, data: exp});
    step();
    ct_valid = 1'b0;
    c1 = cyc;
  endtask

  initial begin
    reset     = 1'b1;
    pt_valid  = 1'b0;
    ct_valid  = 1'b0;
    pt_encr   = '0;
    ct_decr   = '0;
    key_len   = 2'b00;
    short_key = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_flags", 128'({pt_in_en, ct_in_en, key_inp_en, ct_rdy, pt_rdy, key_exp_status, error}),
        128'(7'b1110000));
    chk("rst_ct", ct_encr, '0);
    chk("rst_pt", pt_decr, '0);
    step();
    reset = 1'b0;
    step();

    // No key: blocks are discarded with a one-cycle error pulse.
    pt_valid = 1'b1;
    pt_encr  = PT;
    step();
    pt_valid = 1'b0;
    @(negedge clk);
    chk("nokey_err", 128'(error), 128'(1));
    chk("nokey_pt_in_en", 128'(pt_in_en), 128'(1));
    step();
    @(negedge clk);
    chk("nokey_err_1cyc", 128'(error), 128'(0));
    ct_valid = 1'b1;
    ct_decr  = C2;
    step();
    ct_valid = 1'b0;
    @(negedge clk);
    chk("nokey_ct_err", 128'(error), 128'(1));
    chk("nokey_ct_in_en", 128'(ct_in_en), 128'(1));
    repeat (20) step();
    chk("nokey_no_ct", 128'({ct_rdy, pt_rdy}), 128'(0));

    // Key and plaintext on the same edge, plus a rejected key request mid-expansion.
    key_len   = 2'b11;
    short_key = {K1, 128'h0};
    pt_valid  = 1'b1;
    pt_encr   = P1;
    sb.push_back('{dec: 1'b0, data: C1});
    step();
    key_len  = 2'b00;
    pt_valid = 1'b0;
    @(negedge clk);
    chk("load_status_clr", 128'(key_exp_status), 128'(0));
    chk("load_kinp_low", 128'(key_inp_en), 128'(0));
    chk("pend_in_en_low", 128'(pt_in_en), 128'(0));
    repeat (4) step();
    key_len   = 2'b11;
    short_key = K4;
    step();
    key_len = 2'b00;
    @(negedge clk);
    chk("kexp_err", 128'(error), 128'(1));
    chk("kexp_status", 128'(key_exp_status), 128'(0));
    drain();
    chk("k1_status", 128'(key_exp_status), 128'(1));

    // AES-128 encrypt latency and hold, then decrypt of the same block.
    load_key(2'b11, {K2, 128'h0});
    wait_key();
    send_pt(PT, C2);
    @(negedge clk);
    chk("busy_kinp", 128'(key_inp_en), 128'(0));
    drain();
    chk("lat128", 128'(t_ct - c0), 128'(11));
    repeat (3) step();
    chk("ct_hold", ct_encr, C2);
    send_ct(C2, PT);
    drain();
    chk("dlat128", 128'(t_pt - c1), 128'(11));

    // AES-192 encrypt.
    load_key(2'b10, {K3, 64'h0});
    wait_key();
    send_pt(PT, C3);
    drain();
    chk("lat192", 128'(t_ct - c0), 128'(13));

    // AES-256 decrypt, then both channels on one edge.
    load_key(2'b01, K4);
    wait_key();
    send_ct(C4, PT);
    drain();
    chk("dlat256", 128'(t_pt - c1), 128'(15));
    pt_valid = 1'b1;
    pt_encr  = PT;
    ct_valid = 1'b1;
    ct_decr  = C4;
    sb.push_back('{dec: 1'b0, data: C4});
    sb.push_back('{dec: 1'b1, data: PT});
    step();
    pt_valid = 1'b0;
    ct_valid = 1'b0;
    c0 = cyc;
    drain();
    chk("both_enc_lat", 128'(t_ct - c0), 128'(15));
    chk("both_gap", 128'(t_pt - t_ct), 128'(15));

    // Reset in the middle of a block aborts it.
    pt_valid = 1'b1;
    pt_encr  = P1;
    step();
    pt_valid = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_flags", 128'({pt_in_en, ct_in_en, key_inp_en, ct_rdy, pt_rdy, key_exp_status, error}),
        128'(7'b1110000));
    chk("abort_ct_clr", ct_encr, '0);
    chk("abort_pt_clr", pt_decr, '0);
    repeat (20) step();
    chk("abort_no_ct", 128'({ct_rdy, pt_rdy}), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
